// File: rtl/sat_accum_pkg.sv
// ---------------------------------------------------------------------------
// sat_accum_pkg
//   Shared types and constants for the saturating accumulator.
//   - state_t : accumulator state machine encoding
//   - DW      : datapath width
//   - SAT_POS : largest representable signed value (clamp on positive overflow)
//   - SAT_NEG : smallest representable signed value (clamp on negative overflow)
// ---------------------------------------------------------------------------
package sat_accum_pkg;

    localparam int DW = 16;

    localparam logic [DW-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DW-1:0] SAT_NEG = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sat_add16.sv
// ---------------------------------------------------------------------------
// sat_add16
//   Combinational 16-bit two's-complement add/subtract with saturation.
//   Ports:
//     a    in  DW  signed left operand
//     b    in  DW  signed right operand
//     sub  in  1   1 = a - b, 0 = a + b
//     sum  out DW  clamped result
//     ovf  out 1   result was clamped to SAT_POS or SAT_NEG
// ---------------------------------------------------------------------------
module sat_add16
    import sat_accum_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          sub,
    output logic [DW-1:0] sum,
    output logic          ovf
);

    logic [DW:0] a_ext;
    logic [DW:0] b_ext;
    logic [DW:0] full;

    always_comb begin
        // One extra sign bit holds the exact result of any 16-bit add/sub.
        a_ext = {a[DW-1], a};
        b_ext = {b[DW-1], b};
        full  = sub ? (a_ext - b_ext) : (a_ext + b_ext);

        // The exact result fits in 16 bits iff the top two bits agree.
        ovf = (full[DW] != full[DW-1]);

        if (ovf) begin
            // The extra sign bit tells which way the result ran off the range.
            sum = full[DW] ? SAT_NEG : SAT_POS;
        end else begin
            sum = full[DW-1:0];
        end
    end

endmodule

// File: rtl/sat_accum.sv
// ---------------------------------------------------------------------------
// sat_accum
//   Streaming saturating accumulator. Operands of a packet are added or
//   subtracted into a running 16-bit sum, saturating at every step. The final
//   sum, a sticky overflow flag and the operand count are offered on an
//   output valid/ready handshake.
//   Parameters:
//     CNT_W      width of the operand counter (saturates, never wraps)
//   Ports:
//     clk        in   1      clock, rising edge
//     rst        in   1      asynchronous active-high reset
//     in_valid   in   1      operand valid
//     in_ready   out  1      operand can be accepted (IDLE/ACCUM only)
//     in_data    in   DW     signed operand
//     in_sub     in   1      1 = subtract operand, 0 = add
//     in_last    in   1      final operand of the packet
//     out_valid  out  1      result valid (DONE)
//     out_ready  in   1      consumer takes the result
//     out_sum    out  DW     saturated sum
//     out_ovf    out  1      at least one step saturated
//     out_count  out  CNT_W  operands accepted in the packet
// ---------------------------------------------------------------------------
module sat_accum
    import sat_accum_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_reg;
    state_t           state_next;
    logic [DW-1:0]    acc_reg;
    logic             ovf_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             accept;
    logic             out_fire;
    logic [DW-1:0]    step_sum;
    logic             step_ovf;

    sat_add16 u_sat_add16 (
        .a   (acc_reg),
        .b   (in_data),
        .sub (in_sub),
        .sum (step_sum),
        .ovf (step_ovf)
    );

    // Ready is a pure function of state so there is no in_valid -> in_ready path.
    assign in_ready  = (state_reg != DONE);
    assign out_valid = (state_reg == DONE);
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // The accumulator registers are frozen in DONE, so they double as the
    // held output registers.
    assign out_sum   = acc_reg;
    assign out_ovf   = ovf_reg;
    assign out_count = cnt_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept && in_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            ovf_reg <= 1'b0;
            cnt_reg <= '0;
        end else if (out_fire) begin
            acc_reg <= '0;
            ovf_reg <= 1'b0;
            cnt_reg <= '0;
        end else if (accept) begin
            acc_reg <= step_sum;
            ovf_reg <= ovf_reg | step_ovf;
            cnt_reg <= (cnt_reg == CNT_MAX) ? cnt_reg : (cnt_reg + CNT_ONE);
        end
    end

endmodule

// File: tb/tb_sat_accum.sv
// ---------------------------------------------------------------------------
// tb_sat_accum
//   Directed testbench for sat_accum. Main instance uses CNT_W = 8; a second
//   instance with CNT_W = 2 covers counter saturation.
// ---------------------------------------------------------------------------
module tb_sat_accum;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_sub;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_ovf;
    logic [7:0]  out_count;

    logic        c_in_valid;
    logic        c_in_ready;
    logic [15:0] c_in_data;
    logic        c_in_sub;
    logic        c_in_last;
    logic        c_out_valid;
    logic        c_out_ready;
    logic [15:0] c_out_sum;
    logic        c_out_ovf;
    logic [1:0]  c_out_count;

    int checks;
    int failures;

    sat_accum #(.CNT_W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    sat_accum #(.CNT_W(2)) u_dut_cnt2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (c_in_valid),
        .in_ready  (c_in_ready),
        .in_data   (c_in_data),
        .in_sub    (c_in_sub),
        .in_last   (c_in_last),
        .out_valid (c_out_valid),
        .out_ready (c_out_ready),
        .out_sum   (c_out_sum),
        .out_ovf   (c_out_ovf),
        .out_count (c_out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand to the main instance; ready is expected high.
    task automatic push(input logic [15:0] d, input logic sub, input logic last, input string tag);
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = sub;
        in_last  = last;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_sub   = 1'b0;
        $display("push %s data=0x%04h sub=%0d last=%0d", tag, d, sub, last);
    endtask

    task automatic check_result(input string tag, input logic [15:0] sum, input logic ovf, input logic [7:0] cnt);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_out_sum"},   32'(out_sum),   32'(sum));
        check({tag, "_out_ovf"},   32'(out_ovf),   32'(ovf));
        check({tag, "_out_count"}, 32'(out_count), 32'(cnt));
        $display("result %s sum=0x%04h ovf=%0d count=%0d", tag, out_sum, out_ovf, out_count);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_sub      = 1'b0;
        in_last     = 1'b0;
        out_ready   = 1'b0;
        c_in_valid  = 1'b0;
        c_in_data   = '0;
        c_in_sub    = 1'b0;
        c_in_last   = 1'b0;
        c_out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   32'(out_sum),   32'h0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        // Basic: 5 - 3 = 2, result valid for exactly one cycle
        out_ready = 1'b1;
        push(16'h0005, 1'b0, 1'b0, "basic0");
        check("basic_mid_out_valid", 32'(out_valid), 32'd0);
        push(16'h0003, 1'b1, 1'b1, "basic1");
        check_result("basic", 16'h0002, 1'b0, 8'd2);
        check("basic_in_ready_done", 32'(in_ready), 32'd0);
        step();
        check("basic_valid_drop", 32'(out_valid), 32'd0);
        check("basic_cleared_sum", 32'(out_sum), 32'h0);
        check("basic_cleared_count", 32'(out_count), 32'd0);

        // Positive clamp then recovery from the clamped value
        push(16'h7000, 1'b0, 1'b0, "pos0");
        push(16'h2000, 1'b0, 1'b0, "pos1");
        push(16'h1000, 1'b1, 1'b1, "pos2");
        check_result("pos", 16'h6FFF, 1'b1, 8'd3);
        step();

        // Negative clamp
        push(16'h8000, 1'b0, 1'b0, "neg0");
        push(16'h0001, 1'b1, 1'b1, "neg1");
        check_result("neg", 16'h8000, 1'b1, 8'd2);
        step();
        // 0 - 0x8000 saturates positive
        push(16'h8000, 1'b1, 1'b1, "negmin");
        check_result("negmin", 16'h7FFF, 1'b1, 8'd1);
        step();

        // Backpressure: hold result 5 cycles with a pending operand
        out_ready = 1'b0;
        push(16'h0010, 1'b0, 1'b0, "bp0");
        push(16'h0020, 1'b0, 1'b1, "bp1");
        in_valid = 1'b1;
        in_data  = 16'h0007;
        in_sub   = 1'b0;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_result("bp_hold", 16'h0030, 1'b0, 8'd2);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        check_result("bp_release", 16'h0030, 1'b0, 8'd2);
        step();
        check("bp_idle_out_valid", 32'(out_valid), 32'd0);
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result("bp_next", 16'h0007, 1'b0, 8'd1);
        step();

        // Reset mid-packet
        push(16'h0100, 1'b0, 1'b0, "mid0");
        push(16'h0200, 1'b0, 1'b0, "mid1");
        check("mid_count_before", 32'(out_count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_sum",   32'(out_sum),   32'h0);
        check("midrst_out_ovf",   32'(out_ovf),   32'd0);
        check("midrst_out_count", 32'(out_count), 32'd0);
        step();
        rst = 1'b0;
        #1;
        push(16'h0001, 1'b0, 1'b1, "after_rst");
        check_result("after_rst", 16'h0001, 1'b0, 8'd1);
        step();

        // Counter saturation on the CNT_W = 2 instance
        c_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            c_in_valid = 1'b1;
            c_in_data  = 16'h0001;
            c_in_sub   = 1'b0;
            c_in_last  = (i == 4);
            check("cnt2_in_ready", 32'(c_in_ready), 32'd1);
            step();
            $display("push cnt2 op=%0d data=0x0001", i);
        end
        c_in_valid = 1'b0;
        c_in_last  = 1'b0;
        check("cnt2_out_valid", 32'(c_out_valid), 32'd1);
        check("cnt2_out_sum",   32'(c_out_sum),   32'h0005);
        check("cnt2_out_ovf",   32'(c_out_ovf),   32'd0);
        check("cnt2_out_count", 32'(c_out_count), 32'd3);
        $display("result cnt2 sum=0x%04h ovf=%0d count=%0d", c_out_sum, c_out_ovf, c_out_count);
        step();
        check("cnt2_valid_drop", 32'(c_out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
